// File: rtl/uart_pkg.sv
// Shared UART link constants and the receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 235;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_d,
  output logic out_q
);

  logic meta;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      meta  <= RST_VAL;
      out_q <= RST_VAL;
    end else begin
      meta  <= in_d;
      out_q <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data(MSB first)/stop deserialiser with a held-valid/ack
// byte interface, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_tx,
  input  logic                 in_urx_ack,
  output logic [DATA_BITS-1:0] out_urx_data,
  output logic                 out_urx_vld,
  output logic                 out_urx_ferr,
  output logic                 out_urx_ovr,
  output logic                 out_urx_bs
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned TW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW       = $clog2(DATA_BITS + 1);

  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 half_hit_c;
  logic                 bit_end_c;
  logic                 shift_c;
  logic                 deliver_c;
  logic                 ferr_c;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .in_d   (in_tx),
    .out_q  (rx_s)
  );

  assign half_hit_c = (timer == TW'(HALF_BIT - 1));
  assign bit_end_c  = (timer == TW'(CLKS_PER_BIT - 1));

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_hit_c) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_end_c && (bit_cnt == BW'(DATA_BITS - 1))) state_nxt = STOP;
      STOP:    if (bit_end_c) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes for the datapath
  always_comb begin
    shift_c   = 1'b0;
    deliver_c = 1'b0;
    ferr_c    = 1'b0;
    case (state)
      DATA: shift_c = bit_end_c;
      STOP: begin
        deliver_c = bit_end_c && rx_s;
        ferr_c    = bit_end_c && !rx_s;
      end
      default: ;
    endcase
  end

  // Bit timer restarts on every state change so each phase measures from its entry
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if ((state_nxt != state) || (state == IDLE) || (state == BREAK) || bit_end_c)
        timer <= '0;
      else
        timer <= timer + TW'(1);

      if (state != DATA)  bit_cnt <= '0;
      else if (shift_c)   bit_cnt <= bit_cnt + BW'(1);

      if (shift_c) shreg <= {shreg[DATA_BITS-2:0], rx_s};
    end
  end

  // Consumer interface; a byte arriving while the previous one is unacked is dropped
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_urx_data <= '0;
      out_urx_vld  <= 1'b0;
      out_urx_ovr  <= 1'b0;
      out_urx_ferr <= 1'b0;
      out_urx_bs   <= 1'b0;
    end else begin
      out_urx_ferr <= ferr_c;
      out_urx_bs   <= (state_nxt != IDLE);
      if (deliver_c) begin
        if (!out_urx_vld || in_urx_ack) begin
          out_urx_data <= shreg;
          out_urx_vld  <= 1'b1;
          out_urx_ovr  <= 1'b0;
        end else begin
          out_urx_ovr  <= 1'b1;
        end
      end else if (in_urx_ack && out_urx_vld) begin
        out_urx_vld <= 1'b0;
        out_urx_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the tester's UART link; it is the far end of the existing transmitter.
- Deserialises frames arriving on a single line and presents each byte on a held-valid/ack interface to the consumer (command decoder / result memory).
- Frame format: idle high, 1 start bit (0), DATA_BITS data bits MSB first, 1 stop bit (1).
- 6-bit tester words arrive as 8-bit bytes {2'b00, word[5:0]}.

Parameters:
- CLKS_PER_BIT, 235, clock cycles per bit period.
- DATA_BITS, 8, data bits per frame.
- HALF_BIT, CLKS_PER_BIT/2 (117), offset from detected start edge to first sample point.

Ports:
- in_clk  input  1  system clock, rising edge
- in_rst  input  1  asynchronous reset, active-high
- in_tx  input  1  serial line, asynchronous to in_clk, idle high
- in_urx_ack  input  1  consumer accepts current byte
- out_urx_data  output  DATA_BITS  received byte, stable while out_urx_vld=1
- out_urx_vld  output  1  byte available; held until acknowledged
- out_urx_ferr  output  1  one-cycle pulse: stop bit sampled 0
- out_urx_ovr  output  1  sticky overrun flag, cleared by in_urx_ack
- out_urx_bs  output  1  busy: FSM not in IDLE

Behaviour:
- Reset (async, in_rst=1): state IDLE, counters 0, synchroniser flops 1.
  - out_urx_data=0, out_urx_vld=0, out_urx_ferr=0, out_urx_ovr=0, out_urx_bs=0.
- Synchroniser: in_tx passes through 2 flops; all FSM decisions use the synchronised value (rx_s).
- Bit timer counts 0..CLKS_PER_BIT-1 and reloads to 0. Bit counter counts 0..DATA_BITS-1.
- IDLE:
  - rx_s=0 → START, timer cleared.
- START:
  - At timer==HALF_BIT-1, sample rx_s.
  - 0 → DATA, timer and bit counter cleared.
  - 1 → IDLE (glitch rejected, nothing reported).
- DATA:
  - At timer==CLKS_PER_BIT-1, shift rx_s into the LSB of the shift register (so the first data bit ends up as MSB), then increment the bit counter.
  - After DATA_BITS samples → STOP.
- STOP:
  - At timer==CLKS_PER_BIT-1, sample rx_s.
  - If 1: deliver the byte (see below), then → IDLE.
  - If 0: pulse out_urx_ferr for 1 cycle, discard the byte, → BREAK.
- BREAK:
  - Wait for rx_s=1, then → IDLE. A held-low line yields exactly one ferr pulse.
- Sample timing:
  - Sample k (k=0 start, 1..DATA_BITS data, DATA_BITS+1 stop) occurs HALF_BIT + k*CLKS_PER_BIT cycles after the first cycle rx_s=0 is seen in IDLE.
- Delivery (registered, the cycle after the stop sample):
  - out_urx_vld=0, or in_urx_ack=1 in the same cycle: load out_urx_data, set out_urx_vld=1, no overrun.
  - out_urx_vld=1 and no ack: new byte is dropped, old data is kept, out_urx_ovr<=1.
- Handshake:
  - in_urx_ack while out_urx_vld=1 clears out_urx_vld and out_urx_ovr next cycle.
  - in_urx_ack while out_urx_vld=0 is ignored.
- Latency:
  - With defaults, out_urx_vld rises 2 + 117 + 9*235 + 1 = 2235 cycles after the line's falling start edge (ignoring the synchroniser's sub-cycle uncertainty).
- Back-to-back frames: the next start edge is accepted from IDLE immediately after the stop sample. No idle gap is required beyond the stop bit.
- Reset mid-frame aborts immediately. No partial byte, ferr or vld is produced after release.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - constant UART_CLKS_PER_BIT = 235, shared with the transmitter
  - constant UART_DATA_BITS = 8
- Sub-module sync_2ff (1-bit two-flop synchroniser, reset value parameterised, here 1), reusable for other async inputs.

Test Plan:
- Frame 0x2A (line 0,0,0,1,0,1,0,1,0,1), CLKS_PER_BIT=235 → out_urx_vld rises 2235 cycles after start edge, out_urx_data=8'h2A, ferr=0.
- Loop the existing transmitter with 6-bit words 6'h00, 6'h3F, 6'h15 → received bytes 8'h00, 8'h3F, 8'h15 in order. Ack each within 10 cycles of vld; ovr stays 0.
- 50-cycle low glitch on idle line → FSM returns to IDLE. No vld, no ferr, out_urx_bs high only during the glitch window.
- Frame 0x55 with stop bit forced 0 and line held low 5000 cycles → exactly one ferr pulse, vld stays 0. Next valid frame 0xA5 after line release is received correctly.
- Two back-to-back frames 0x11, 0x22 with no ack → data=8'h11 held, ovr=1 after second stop. Ack → vld=0, ovr=0. Ack asserted in the same cycle as delivery of a third byte 0x33 → data=8'h33, vld=1, ovr=0.
- Assert in_rst during data bit 4 of a frame, release, then send 0x7E → no spurious output from the aborted frame; 0x7E received exactly once.
